// File: rtl/ball_motion.sv
// Pong ball engine: per-frame position/velocity update, wall bounce, paddle deflection,
// miss detection and re-serve. Optional feature macro: BALL_SPEEDUP_EN (speed-up on paddle hits).
module ball_motion #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BALL_LEN      = 15,
  parameter int SPEED_X       = 4,
  parameter int SERVE_DY      = 2,
  parameter int MAX_DY        = 6,
  parameter int DEFLECT_SHIFT = 2,
  parameter int SERVE_DELAY   = 60,
  parameter int MAX_SPEED_X   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              paddle1_hit,
  input  logic              paddle2_hit,
  input  logic signed [9:0] hit_intersect,
  output logic        [9:0] ball_x_min,
  output logic        [8:0] ball_y_min,
  output logic              p1_point,
  output logic              p2_point,
  output logic              in_play
);

  localparam int CNT_W    = $clog2(SERVE_DELAY + 1);
  localparam int SPD_W    = $clog2(MAX_SPEED_X + 1);
  localparam int X_CENTRE = (SCREEN_WIDTH - BALL_LEN) / 2;
  localparam int Y_CENTRE = (SCREEN_HEIGHT - BALL_LEN) / 2;
  localparam int Y_MAX    = SCREEN_HEIGHT - BALL_LEN;

  localparam logic signed [10:0] MAX_DY_S   = 11'(MAX_DY);
  localparam logic signed [10:0] Y_MAX_S    = 11'(Y_MAX);
  localparam logic signed [4:0]  SERVE_DY_S = 5'(SERVE_DY);

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_PLAY  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic               dir_right_q, dir_right_d;
  logic signed [4:0]  dy_q, dy_d;
  logic               serve_pos_q, serve_pos_d;
  logic               p1_q, p1_d;
  logic               p2_q, p2_d;

  logic [SPD_W-1:0]   speed;
  logic               hit_accept;
  logic               recentre;
  logic               miss_left;
  logic               miss_right;
  logic signed [9:0]  hit_shr;
  logic signed [10:0] hit_neg;
  logic signed [4:0]  dy_hit;
  logic signed [4:0]  dy_x;
  logic signed [10:0] y_sum;

  // Deflection: dy = -(hit_intersect >>> shift), clamped to +/-MAX_DY.
  assign hit_shr = hit_intersect >>> DEFLECT_SHIFT;
  assign hit_neg = -{hit_shr[9], hit_shr};

  always_comb begin
    if (hit_neg > MAX_DY_S)       dy_hit = 5'(MAX_DY_S);
    else if (hit_neg < -MAX_DY_S) dy_hit = 5'(-MAX_DY_S);
    else                          dy_hit = hit_neg[4:0];
  end

  assign miss_left  = !dir_right_q && (x_q < 10'(speed));
  assign miss_right = dir_right_q &&
                      (({2'b00, x_q} + 12'(BALL_LEN) + 12'(speed)) > 12'(SCREEN_WIDTH));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_right_d = dir_right_q;
    dy_d        = dy_q;
    serve_pos_d = serve_pos_q;
    p1_d        = 1'b0;
    p2_d        = 1'b0;
    hit_accept  = 1'b0;
    recentre    = 1'b0;
    dy_x        = dy_q;
    y_sum       = '0;

    if (frame_tick) begin
      case (state_q)
        ST_SERVE: begin
          if (serve_cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
        ST_PLAY: begin
          if (!dir_right_q && paddle1_hit) begin
            hit_accept  = 1'b1;
            dir_right_d = 1'b1;
            x_d         = x_q + 10'(speed);
          end else if (dir_right_q && paddle2_hit) begin
            hit_accept  = 1'b1;
            dir_right_d = 1'b0;
            x_d         = x_q - 10'(speed);
          end else if (miss_left || miss_right) begin
            recentre    = 1'b1;
            p2_d        = miss_left;
            p1_d        = miss_right;
            dir_right_d = miss_right;
          end else begin
            x_d = dir_right_q ? x_q + 10'(speed) : x_q - 10'(speed);
          end

          // Vertical motion uses the dy chosen by the x stage on this tick.
          if (hit_accept) dy_x = dy_hit;
          y_sum = $signed({2'b00, y_q}) + dy_x;
          if (!recentre) begin
            if (y_sum < 0) begin
              y_d  = '0;
              dy_d = -dy_x;
            end else if (y_sum > Y_MAX_S) begin
              y_d  = 9'(Y_MAX);
              dy_d = -dy_x;
            end else begin
              y_d  = y_sum[8:0];
              dy_d = dy_x;
            end
          end

          if (recentre) begin
            state_d     = ST_SERVE;
            serve_cnt_d = '0;
            x_d         = 10'(X_CENTRE);
            y_d         = 9'(Y_CENTRE);
            serve_pos_d = !serve_pos_q;
            dy_d        = serve_pos_d ? SERVE_DY_S : -SERVE_DY_S;
          end
        end
        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q     <= ST_SERVE;
      serve_cnt_q <= '0;
      x_q         <= 10'(X_CENTRE);
      y_q         <= 9'(Y_CENTRE);
      dir_right_q <= 1'b1;
      dy_q        <= SERVE_DY_S;
      serve_pos_q <= 1'b1;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_right_q <= dir_right_d;
      dy_q        <= dy_d;
      serve_pos_q <= serve_pos_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [SPD_W-1:0] speed_q, speed_d;

  always_comb begin
    speed_d = speed_q;
    if (recentre)
      speed_d = SPD_W'(SPEED_X);
    else if (hit_accept && (speed_q < SPD_W'(MAX_SPEED_X)))
      speed_d = speed_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) speed_q <= SPD_W'(SPEED_X);
    else       speed_q <= speed_d;
  end

  assign speed = speed_q;
`else
  assign speed = SPD_W'(SPEED_X);
`endif

  assign ball_x_min = x_q;
  assign ball_y_min = y_q;
  assign p1_point   = p1_q;
  assign p2_point   = p2_q;
  assign in_play    = (state_q == ST_PLAY);

endmodule
